// File: rtl/bike_pkg.sv
// Shared BIKE-2 constants, RNG request encodings and sampler state type.
package bike_pkg;

    localparam int L1_R     = 10163;
    localparam int L1_W     = 71;
    localparam int L1_IDX_W = 14;

    localparam int L3_R     = 19853;
    localparam int L3_W     = 103;
    localparam int L3_IDX_W = 15;

    localparam logic [1:0] RNG_IDLE = 2'b00;
    localparam logic [1:0] RNG_NEXT = 2'b01;
    localparam logic [1:0] RNG_SEED = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LANE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } sampler_state_e;

    function automatic logic state_is_busy(input sampler_state_e s);
        return !(s == ST_IDLE || s == ST_DONE);
    endfunction

endpackage

// File: rtl/sparse_idx_mem.sv
// Append-only index store: writes land at position count, reads are asynchronous.
module sparse_idx_mem #(
    parameter int DEPTH = 71,
    parameter int IDX_W = 14,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [IDX_W-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (we) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents are never reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[count_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
    assign count = count_q;

endmodule

// File: rtl/bike_sparse_sampler.sv
// Rejection/duplicate-free sampler of W distinct indices in [0, R) from 64-bit RNG words.
module bike_sparse_sampler
    import bike_pkg::*;
#(
    parameter int R     = L1_R,
    parameter int W     = L1_W,
    parameter int IDX_W = L1_IDX_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    output logic [1:0]       rng_start,
    input  logic             rng_valid,
    input  logic [63:0]      rng_in,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(W + 1);
    localparam int AW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] R_LIM  = IDX_W'(R);
    localparam logic [CW-1:0]    W_LAST = CW'(W - 1);

    sampler_state_e   state_q, state_d;
    logic [63:0]      word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic             idx_valid_q, idx_valid_d;
    logic [IDX_W-1:0] idx_out_q, idx_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             mem_clr, mem_we;
    logic [IDX_W-1:0] mem_rdata;
    logic [CW-1:0]    mem_count;
    logic [IDX_W-1:0] lane_cand;

    sparse_idx_mem #(.DEPTH(W), .IDX_W(IDX_W)) u_mem (
        .clk   (clk),
        .srst  (rst_b),
        .clr   (mem_clr),
        .we    (mem_we),
        .wdata (cand_q),
        .raddr (ptr_q[AW-1:0]),
        .rdata (mem_rdata),
        .count (mem_count)
    );

    // Upper lane bits beyond IDX_W are simply dropped.
    assign lane_cand = word_q[{lane_q, 4'b0000} +: IDX_W];

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        lane_d    = lane_q;
        cand_d    = cand_q;
        ptr_d     = ptr_q;
        idx_out_d = idx_out_q;
        mem_clr   = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mem_clr = 1'b1;
                    lane_d  = 2'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rng_valid) begin
                    word_d  = rng_in;
                    lane_d  = 2'd0;
                    state_d = ST_LANE;
                end
            end
            ST_LANE: begin
                if (lane_cand >= R_LIM) begin
                    lane_d  = lane_q + 2'd1;
                    state_d = (lane_q == 2'd3) ? ST_REQ : ST_LANE;
                end else begin
                    cand_d  = lane_cand;
                    ptr_d   = '0;
                    state_d = (mem_count == '0) ? ST_EMIT : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mem_rdata == cand_q) begin
                    lane_d  = lane_q + 2'd1;
                    state_d = (lane_q == 2'd3) ? ST_REQ : ST_LANE;
                end else if (ptr_q == mem_count - CW'(1)) begin
                    state_d = ST_EMIT;
                end else begin
                    ptr_d = ptr_q + CW'(1);
                end
            end
            ST_EMIT: begin
                if (idx_ready) begin
                    mem_we = 1'b1;
                    if (mem_count == W_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d  = lane_q + 2'd1;
                        state_d = (lane_q == 2'd3) ? ST_REQ : ST_LANE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they change with it.
        idx_valid_d = (state_d == ST_EMIT);
        busy_d      = state_is_busy(state_d);
        done_d      = (state_d == ST_DONE);
        if (state_d == ST_EMIT && state_q != ST_EMIT) begin
            idx_out_d = cand_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            lane_q      <= '0;
            cand_q      <= '0;
            ptr_q       <= '0;
            idx_valid_q <= 1'b0;
            idx_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            cand_q      <= cand_d;
            ptr_q       <= ptr_d;
            idx_valid_q <= idx_valid_d;
            idx_out_q   <= idx_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rng_start = (state_q == ST_REQ) ? RNG_NEXT : RNG_IDLE;
    assign idx_valid = idx_valid_q;
    assign idx_out   = idx_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bike_sparse_sampler.sv
// Directed bench for bike_sparse_sampler (W=4) with a scripted two-cycle-latency RNG stub.
module tb_bike_sparse_sampler;

    localparam int R     = 10163;
    localparam int W     = 4;
    localparam int IDX_W = 14;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             start;
    logic [1:0]       rng_start;
    logic             rng_valid;
    logic [63:0]      rng_in;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_out;
    logic             busy;
    logic             done;

    logic [63:0] words [6];
    int          widx      = 0;
    int          req_count = 0;
    int          pend      = 0;
    int          passes    = 0;
    int          total     = 0;

    bike_sparse_sampler #(.R(R), .W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .rng_start (rng_start),
        .rng_valid (rng_valid),
        .rng_in    (rng_in),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_out   (idx_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // RNG stub: answers each request two cycles after the REQ cycle.
    initial begin
        rng_valid = 1'b0;
        rng_in    = '0;
        forever begin
            @(negedge clk);
            rng_valid = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    rng_valid = 1'b1;
                    rng_in    = words[widx];
                    widx      = widx + 1;
                end
            end
            if (rng_start == 2'b01) begin
                pend      = 2;
                req_count = req_count + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Waits for idx_valid, checks value (and latency if exp_lat >= 0), then handshakes.
    task automatic take_idx(input string tag, input int exp_val, input int exp_lat);
        int lat;
        lat = 0;
        while (!idx_valid && lat < 200) begin
            tick();
            lat = lat + 1;
        end
        check({tag, "_valid"}, 64'(idx_valid), 64'd1);
        check({tag, "_value"}, 64'(idx_out), 64'(exp_val));
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        $display("idx %s: value=%0d latency=%0d", tag, idx_out, lat);
        idx_ready = 1'b1;
        tick();
        idx_ready = 1'b0;
        check({tag, "_drop"}, 64'(idx_valid), 64'd0);
    endtask

    initial begin
        words[0] = 64'h0003_0002_0001_0000;
        words[1] = 64'h27B2_C005_27B2_27B3;
        words[2] = 64'h0007_0005_0005_0005;
        words[3] = 64'h0000_0000_0000_0100;
        words[4] = 64'h000D_000C_000B_000A;
        words[5] = 64'h0020_001F_000B_001E;

        rst_b     = 1'b1;
        start     = 1'b0;
        idx_ready = 1'b0;
        tick();
        tick();
        check("rst_rng_start", 64'(rng_start), 64'd0);
        check("rst_idx_valid", 64'(idx_valid), 64'd0);
        check("rst_idx_out", 64'(idx_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_b = 1'b0;
        tick();

        // Run 1: ascending lanes, one request, latency 1 LANE + k SCAN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_rng_req", 64'(rng_start), 64'd1);
        check("r1_busy", 64'(busy), 64'd1);
        take_idx("r1_i0", 0, 4);
        take_idx("r1_i1", 1, 2);
        take_idx("r1_i2", 2, 3);
        take_idx("r1_i3", 3, 4);
        check("r1_done", 64'(done), 64'd1);
        check("r1_busy_low", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("r1_req_count", 64'(req_count), 64'd1);
        check("r1_done_held", 64'(done), 64'd1);

        // Run 2: range boundary, masked lane, duplicates, back-pressure
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_done_clear", 64'(done), 64'd0);
        check("r2_rng_req", 64'(rng_start), 64'd1);
        take_idx("r2_i0", 10162, -1);
        take_idx("r2_i1", 5, -1);
        take_idx("r2_i2", 7, -1);
        begin
            int lat;
            lat = 0;
            while (!idx_valid && lat < 200) begin
                tick();
                lat = lat + 1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("r2_hold_valid", 64'(idx_valid), 64'd1);
            check("r2_hold_out", 64'(idx_out), 64'd256);
            tick();
        end
        check("r2_hold_req_count", 64'(req_count), 64'd4);
        check("r2_hold_not_done", 64'(done), 64'd0);
        take_idx("r2_i3", 256, 0);
        check("r2_done", 64'(done), 64'd1);
        check("r2_busy_low", 64'(busy), 64'd0);

        // Run 3: reset while scanning with count=3, then a fresh run
        start = 1'b1;
        tick();
        start = 1'b0;
        take_idx("r3_i0", 10, -1);
        take_idx("r3_i1", 11, 2);
        take_idx("r3_i2", 12, 3);
        tick();
        tick();
        check("r3_scan_busy", 64'(busy), 64'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("r3_rst_rng_start", 64'(rng_start), 64'd0);
        check("r3_rst_idx_valid", 64'(idx_valid), 64'd0);
        check("r3_rst_idx_out", 64'(idx_out), 64'd0);
        check("r3_rst_busy", 64'(busy), 64'd0);
        check("r3_rst_done", 64'(done), 64'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        take_idx("r4_i0", 30, 4);
        take_idx("r4_i1", 11, 2);
        take_idx("r4_i2", 31, 3);
        take_idx("r4_i3", 32, 4);
        check("r4_done", 64'(done), 64'd1);
        check("r4_req_count", 64'(req_count), 64'd6);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
